microc_param: RTL and testbench

Parametrised single-cycle microcontroller datapath, the successor to the fixed 8-bit/10-bit-PC datapath. It adds configurable data, register-address and PC widths, and a hardware call/return stack with overflow/underflow detection. Zero and carry are registered flags with an explicit write enable. The block sits between the external control unit (which decodes `opcode` and drives the select/enable inputs) and an external combinational-read program memory.

---
 rtl/microc_pkg.sv | 45 ++++
 rtl/microc_param_ret_stack.sv | 66 ++++++
 rtl/microc_param.sv | 145 ++++++++++++++
 tb/tb_microc_param.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/microc_pkg.sv
// microc_pkg: shared ALU op codes, opcode width and instruction field extractors.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package microc_pkg;

  localparam int OPCODE_W = 6;

  localparam logic [2:0] ALU_PASSA = 3'b000;
  localparam logic [2:0] ALU_NOTA  = 3'b001;
  localparam logic [2:0] ALU_ADD   = 3'b010;
  localparam logic [2:0] ALU_SUB   = 3'b011;
  localparam logic [2:0] ALU_AND   = 3'b100;
  localparam logic [2:0] ALU_OR    = 3'b101;
  localparam logic [2:0] ALU_NEGA  = 3'b110;
  localparam logic [2:0] ALU_NEGB  = 3'b111;

  // Instructions are handed in zero-extended to 64 bits so one set of
  // extractors serves every IW; callers cast the result to the field width.
  function automatic logic [63:0] f_field(input logic [63:0] instr, input int lsb,
                                          input int width);
    return (instr >> lsb) & ((64'd1 << width) - 64'd1);
  endfunction

  function automatic logic [63:0] f_ra1(input logic [63:0] instr, input int reg_aw);
    return f_field(instr, 2 * reg_aw, reg_aw);
  endfunction

  function automatic logic [63:0] f_ra2(input logic [63:0] instr, input int reg_aw);
    return f_field(instr, reg_aw, reg_aw);
  endfunction

  function automatic logic [63:0] f_wa3(input logic [63:0] instr, input int reg_aw);
    return f_field(instr, 0, reg_aw);
  endfunction

  function automatic logic [63:0] f_inm(input logic [63:0] instr, input int reg_aw,
                                        input int data_w);
    return f_field(instr, reg_aw, data_w);
  endfunction

  function automatic logic [63:0] f_off(input logic [63:0] instr, input int pc_w);
    return f_field(instr, 0, pc_w);
  endfunction

endpackage

// File: rtl/microc_param_ret_stack.sv
// ret_stack: return-address LIFO with sticky overflow/underflow/conflict error.
// Latency: push/pop commit on the rising edge; pop_data/empty/full are combinational from sp.
// Backpressure: none; an illegal push/pop is dropped and flagged on err.
// Ports: clk, reset (sync, active-high); call/ret requests; push_data in;
//        pop_data (current top), empty, full, err out.
module ret_stack
  import microc_pkg::*;
#(
  parameter int PC_W        = 10,
  parameter int STACK_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            call,
  input  logic            ret,
  input  logic [PC_W-1:0] push_data,
  output logic [PC_W-1:0] pop_data,
  output logic            empty,
  output logic            full,
  output logic            err
);

  localparam int SP_W = $clog2(STACK_DEPTH + 1);

  logic [SP_W-1:0] sp;
  logic [PC_W-1:0] mem [STACK_DEPTH];
  logic            do_push;
  logic            do_pop;
  logic            bad;

  assign full  = (sp == SP_W'(STACK_DEPTH));
  assign empty = (sp == '0);

  // Simultaneous call+ret is treated as a conflict: neither side acts.
  assign do_push = call & ~ret & ~full;
  assign do_pop  = ret & ~call & ~empty;
  assign bad     = (call & ret) | (ret & empty) | (call & full);

  // Top of stack is entry sp-1; selected by compare so no index ever
  // falls outside the storage when sp is 0.
  always_comb begin
    pop_data = '0;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (sp == SP_W'(i + 1)) pop_data = mem[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sp  <= '0;
      err <= 1'b0;
    end else begin
      if (do_push)     sp <= sp + SP_W'(1);
      else if (do_pop) sp <= sp - SP_W'(1);
      if (bad) err <= 1'b1;
    end
  end

  // Storage survives reset; only the pointer is cleared.
  always_ff @(posedge clk) begin
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (!reset && do_push && sp == SP_W'(i)) mem[i] <= push_data;
    end
  end

endmodule

// File: rtl/microc_param.sv
// microc_param: parametrised single-cycle microcontroller datapath with call/return stack.
// Latency: one instruction per cycle; PC, registers, flags and stack commit on the next edge.
// Backpressure: none; the external control unit drives every select each cycle.
// Ports: clk, reset (sync, active-high); imem_addr/imem_data program memory
//        interface; opcode to control unit; s_inc, s_skip, s_inm, we, flag_we,
//        s_call, s_ret, alu_op controls in; zero, carry, stack_full, stack_err out.
module microc_param
  import microc_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int REG_AW      = 4,
  parameter int PC_W        = 10,
  parameter int STACK_DEPTH = 4,
  parameter int IW          = 16
) (
  input  logic                clk,
  input  logic                reset,
  output logic [PC_W-1:0]     imem_addr,
  input  logic [IW-1:0]       imem_data,
  output logic [OPCODE_W-1:0] opcode,
  input  logic                s_inc,
  input  logic                s_skip,
  input  logic                s_inm,
  input  logic                we,
  input  logic                flag_we,
  input  logic                s_call,
  input  logic                s_ret,
  input  logic [2:0]          alu_op,
  output logic                zero,
  output logic                carry
  ,
  output logic                stack_full,
  output logic                stack_err
);

  logic [63:0]       instr;
  logic [REG_AW-1:0] ra1;
  logic [REG_AW-1:0] ra2;
  logic [REG_AW-1:0] wa3;
  logic [DATA_W-1:0] inm;
  logic [PC_W-1:0]   offset;

  logic [PC_W-1:0]   pc;
  logic [PC_W-1:0]   pc_plus1;
  logic [PC_W-1:0]   pc_next;

  logic [DATA_W-1:0] rf [2**REG_AW];
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;
  logic [DATA_W-1:0] wd;

  logic [DATA_W:0]   alu_wide;
  logic [DATA_W-1:0] alu_res;
  logic              alu_zero;
  logic              alu_carry;

  logic [PC_W-1:0]   pop_data;
  logic              stack_empty;

  // Decode: with small IW the fields may overlap the opcode bits; the
  // control unit decides which fields are meaningful for each opcode.
  assign instr  = 64'(imem_data);
  assign opcode = imem_data[IW-1 -: OPCODE_W];
  assign ra1    = REG_AW'(f_ra1(instr, REG_AW));
  assign ra2    = REG_AW'(f_ra2(instr, REG_AW));
  assign wa3    = REG_AW'(f_wa3(instr, REG_AW));
  assign inm    = DATA_W'(f_inm(instr, REG_AW, DATA_W));
  assign offset = PC_W'(f_off(instr, PC_W));

  // Register file: R0 is hardwired to zero, entry 0 is never written.
  assign rd1 = (ra1 == '0) ? '0 : rf[ra1];
  assign rd2 = (ra2 == '0) ? '0 : rf[ra2];
  assign wd  = s_inm ? inm : alu_res;

  always_ff @(posedge clk) begin
    if (!reset && we && wa3 != '0) rf[wa3] <= wd;
  end

  // ALU computed one bit wide so bit DATA_W is the carry/borrow for the
  // arithmetic ops; the logical ops leave that bit at 0 by construction.
  always_comb begin
    alu_wide = '0;
    case (alu_op)
      ALU_PASSA: alu_wide = {1'b0, rd1};
      ALU_NOTA:  alu_wide = {1'b0, ~rd1};
      ALU_ADD:   alu_wide = {1'b0, rd1} + {1'b0, rd2};
      ALU_SUB:   alu_wide = {1'b0, rd1} - {1'b0, rd2};
      ALU_AND:   alu_wide = {1'b0, rd1 & rd2};
      ALU_OR:    alu_wide = {1'b0, rd1 | rd2};
      ALU_NEGA:  alu_wide = '0 - {1'b0, rd1};
      ALU_NEGB:  alu_wide = '0 - {1'b0, rd2};
      default:   alu_wide = '0;
    endcase
  end

  assign alu_res   = alu_wide[DATA_W-1:0];
  assign alu_carry = alu_wide[DATA_W];
  assign alu_zero  = (alu_res == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      zero  <= 1'b0;
      carry <= 1'b0;
    end else if (flag_we) begin
      zero  <= alu_zero;
      carry <= alu_carry;
    end
  end

  ret_stack #(
    .PC_W        (PC_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk       (clk),
    .reset     (reset),
    .call      (s_call),
    .ret       (s_ret),
    .push_data (pc_plus1),
    .pop_data  (pop_data),
    .empty     (stack_empty),
    .full      (stack_full),
    .err       (stack_err)
  );

  // Next-PC priority: conflict, return, call, sequential, relative jump.
  // A full stack still lets the call jump; the lost return is flagged.
  assign pc_plus1 = pc + PC_W'(1);

  always_comb begin
    pc_next = pc_plus1;
    if (s_call && s_ret)  pc_next = pc_plus1;
    else if (s_ret)       pc_next = stack_empty ? pc_plus1 : pop_data;
    else if (s_call)      pc_next = offset;
    else if (s_inc)       pc_next = pc + (s_skip ? PC_W'(2) : PC_W'(1));
    else                  pc_next = pc + offset;
  end

  always_ff @(posedge clk) begin
    if (reset) pc <= '0;
    else       pc <= pc_next;
  end

  assign imem_addr = pc;

endmodule

// File: tb/tb_microc_param.sv
module tb_microc_param;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int PW = 10;
  localparam int SD = 4;
  localparam int IWB = 16;

  localparam int C_INC  = 1;
  localparam int C_SKIP = 2;
  localparam int C_INM  = 4;
  localparam int C_WE   = 8;
  localparam int C_FWE  = 16;
  localparam int C_CALL = 32;
  localparam int C_RET  = 64;
  localparam int C_RST  = 128;

  logic           clk;
  logic           reset;
  logic [PW-1:0]  imem_addr;
  logic [IWB-1:0] imem_data;
  logic [5:0]     opcode;
  logic           s_inc, s_skip, s_inm, we, flag_we, s_call, s_ret;
  logic [2:0]     alu_op;
  logic           zero, carry, stack_full, stack_err;

  int checks = 0;
  int passed = 0;

  // Behavioural reference state
  int m_pc;
  int m_regs [16];
  int m_stk [$];
  bit m_zero, m_carry, m_err;

  microc_param #(
    .DATA_W(DW), .REG_AW(AW), .PC_W(PW), .STACK_DEPTH(SD), .IW(IWB)
  ) dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_data(imem_data),
    .opcode(opcode), .s_inc(s_inc), .s_skip(s_skip), .s_inm(s_inm), .we(we),
    .flag_we(flag_we), .s_call(s_call), .s_ret(s_ret), .alu_op(alu_op),
    .zero(zero), .carry(carry), .stack_full(stack_full), .stack_err(stack_err)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] mk_off(int off);
    return 16'(off & 1023);
  endfunction

  function automatic logic [15:0] mk_rrr(int a1, int a2, int a3);
    return 16'((a1 << 8) | (a2 << 4) | a3);
  endfunction

  function automatic logic [15:0] mk_imm(int imm, int a3);
    return 16'(((imm & 255) << 4) | a3);
  endfunction

  // Drive one instruction, advance the reference model, clock once, and
  // return 1ns after the edge so outputs can be sampled.
  task automatic step(input logic [15:0] ins, input logic [2:0] op, input int ctl);
    int a, b, r, ra1, ra2, wa3, imm, off;
    bit c;
    imem_data = ins;
    alu_op    = op;
    s_inc     = (ctl & C_INC) != 0;
    s_skip    = (ctl & C_SKIP) != 0;
    s_inm     = (ctl & C_INM) != 0;
    we        = (ctl & C_WE) != 0;
    flag_we   = (ctl & C_FWE) != 0;
    s_call    = (ctl & C_CALL) != 0;
    s_ret     = (ctl & C_RET) != 0;
    reset     = (ctl & C_RST) != 0;

    ra1 = (int'(ins) >> 8) & 15;
    ra2 = (int'(ins) >> 4) & 15;
    wa3 = int'(ins) & 15;
    imm = (int'(ins) >> 4) & 255;
    off = int'(ins) & 1023;
    a = (ra1 == 0) ? 0 : m_regs[ra1];
    b = (ra2 == 0) ? 0 : m_regs[ra2];
    c = 0;
    case (int'(op))
      0: r = a;
      1: r = (~a) & 255;
      2: begin r = a + b; c = (r > 255); end
      3: begin r = a - b; c = (a < b); end
      4: r = a & b;
      5: r = a | b;
      6: begin r = -a; c = (a != 0); end
      default: begin r = -b; c = (b != 0); end
    endcase

    if (reset) begin
      m_pc = 0; m_zero = 0; m_carry = 0; m_err = 0;
      m_stk.delete();
    end else begin
      if (flag_we) begin
        m_zero  = ((r & 255) == 0);
        m_carry = c;
      end
      if (we && wa3 != 0) m_regs[wa3] = s_inm ? imm : (r & 255);
      if (s_call && s_ret) begin
        m_pc = (m_pc + 1) & 1023;
        m_err = 1;
      end else if (s_ret) begin
        if (m_stk.size() == 0) begin
          m_pc = (m_pc + 1) & 1023;
          m_err = 1;
        end else m_pc = m_stk.pop_back();
      end else if (s_call) begin
        if (m_stk.size() < SD) m_stk.push_back((m_pc + 1) & 1023);
        else m_err = 1;
        m_pc = off;
      end else if (s_inc) m_pc = (m_pc + (s_skip ? 2 : 1)) & 1023;
      else m_pc = (m_pc + off) & 1023;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step(16'h0, 3'd0, C_RST | C_INC);
    checks++; if (imem_addr !== 10'h000) $display("FAIL reset_pc: got %0h expected 0", imem_addr); else passed++;
    checks++; if (zero !== 1'b0) $display("FAIL reset_zero: got %b expected 0", zero); else passed++;
    checks++; if (carry !== 1'b0) $display("FAIL reset_carry: got %b expected 0", carry); else passed++;
    checks++; if (stack_full !== 1'b0) $display("FAIL reset_full: got %b expected 0", stack_full); else passed++;
    checks++; if (stack_err !== 1'b0) $display("FAIL reset_err: got %b expected 0", stack_err); else passed++;
  endtask

  task automatic test_inc();
    for (int i = 1; i <= 3; i++) begin
      step(16'h0, 3'd0, C_INC);
      checks++;
      if (imem_addr !== 10'(i)) $display("FAIL inc_pc: got %0h expected %0h", imem_addr, i);
      else passed++;
    end
    step(16'h0, 3'd0, C_INC | C_SKIP);
    checks++; if (imem_addr !== 10'h005) $display("FAIL skip_pc: got %0h expected 5", imem_addr); else passed++;
  endtask

  task automatic test_wrap();
    step(mk_off(10'h3F9), 3'd0, 0);
    checks++; if (imem_addr !== 10'h3FE) $display("FAIL rel_jump: got %0h expected 3fe", imem_addr); else passed++;
    step(mk_off(10'h005), 3'd0, 0);
    checks++; if (imem_addr !== 10'h003) $display("FAIL wrap_jump: got %0h expected 3", imem_addr); else passed++;
  endtask

  task automatic test_alu();
    step(mk_imm(8'hF0, 1), 3'd0, C_INC | C_INM | C_WE);
    step(mk_imm(8'h20, 2), 3'd0, C_INC | C_INM | C_WE);
    step(mk_rrr(1, 2, 3), 3'b010, C_INC | C_WE | C_FWE);
    checks++; if (carry !== 1'b1) $display("FAIL add_carry: got %b expected 1", carry); else passed++;
    checks++; if (zero !== 1'b0) $display("FAIL add_zero: got %b expected 0", zero); else passed++;
    step(mk_rrr(1, 1, 0), 3'b011, C_INC | C_FWE);
    checks++; if (zero !== 1'b1) $display("FAIL sub_zero: got %b expected 1", zero); else passed++;
    checks++; if (carry !== 1'b0) $display("FAIL sub_carry: got %b expected 0", carry); else passed++;
    // R3 must hold 0x10: compare against a freshly loaded 0x10
    step(mk_imm(8'h10, 4), 3'd0, C_INC | C_INM | C_WE);
    step(mk_rrr(2, 0, 0), 3'b000, C_INC | C_FWE);
    checks++; if (zero !== 1'b0) $display("FAIL passa_r2_zero: got %b expected 0", zero); else passed++;
    step(mk_rrr(3, 4, 0), 3'b011, C_INC | C_FWE);
    checks++; if (zero !== 1'b1) $display("FAIL r3_value_zero: got %b expected 1", zero); else passed++;
    // R0 ignores writes
    step(mk_rrr(2, 0, 0), 3'b000, C_INC | C_FWE);
    step(mk_imm(8'h55, 0), 3'd0, C_INC | C_INM | C_WE);
    step(mk_rrr(0, 0, 0), 3'b000, C_INC | C_FWE);
    checks++; if (zero !== 1'b1) $display("FAIL r0_reads_zero: got %b expected 1", zero); else passed++;
    step(mk_rrr(2, 0, 0), 3'b110, C_INC | C_FWE);
    checks++; if (carry !== 1'b1) $display("FAIL nega_carry: got %b expected 1", carry); else passed++;
  endtask

  task automatic test_calls();
    int tgt [4] = '{10'h100, 10'h200, 10'h300, 10'h180};
    int rets [4] = '{10'h301, 10'h201, 10'h101, 10'h011};
    step(mk_off(10'h010 - m_pc), 3'd0, 0);
    checks++; if (imem_addr !== 10'h010) $display("FAIL goto_010: got %0h expected 10", imem_addr); else passed++;
    for (int i = 0; i < 4; i++) begin
      step(mk_off(tgt[i]), 3'd0, C_CALL);
      checks++;
      if (imem_addr !== 10'(tgt[i])) $display("FAIL call_pc: got %0h expected %0h", imem_addr, tgt[i]);
      else passed++;
      checks++;
      if (stack_full !== (i == 3)) $display("FAIL call_full: got %b expected %b", stack_full, i == 3);
      else passed++;
    end
    checks++; if (stack_err !== 1'b0) $display("FAIL call4_err: got %b expected 0", stack_err); else passed++;
    step(mk_off(10'h050), 3'd0, C_CALL);
    checks++; if (imem_addr !== 10'h050) $display("FAIL overflow_pc: got %0h expected 50", imem_addr); else passed++;
    checks++; if (stack_err !== 1'b1) $display("FAIL overflow_err: got %b expected 1", stack_err); else passed++;
    checks++; if (stack_full !== 1'b1) $display("FAIL overflow_full: got %b expected 1", stack_full); else passed++;
    for (int i = 0; i < 4; i++) begin
      step(16'h0, 3'd0, C_RET);
      checks++;
      if (imem_addr !== 10'(rets[i])) $display("FAIL ret_pc: got %0h expected %0h", imem_addr, rets[i]);
      else passed++;
    end
    checks++; if (stack_full !== 1'b0) $display("FAIL ret_full: got %b expected 0", stack_full); else passed++;
    step(16'h0, 3'd0, C_RET);
    checks++; if (imem_addr !== 10'h012) $display("FAIL underflow_pc: got %0h expected 12", imem_addr); else passed++;
    checks++; if (stack_err !== 1'b1) $display("FAIL underflow_err: got %b expected 1", stack_err); else passed++;
  endtask

  task automatic test_conflict();
    step(16'h0, 3'd0, C_RST);
    step(mk_off(10'h001), 3'd0, C_CALL);
    step(mk_off(10'h020 - m_pc), 3'd0, 0);
    step(mk_off(10'h155), 3'd0, C_CALL | C_RET);
    checks++; if (imem_addr !== 10'h021) $display("FAIL conflict_pc: got %0h expected 21", imem_addr); else passed++;
    checks++; if (stack_err !== 1'b1) $display("FAIL conflict_err: got %b expected 1", stack_err); else passed++;
    // sp unchanged: the single earlier push (return address 1) is still on top
    step(16'h0, 3'd0, C_RET);
    checks++; if (imem_addr !== 10'h001) $display("FAIL conflict_sp: got %0h expected 1", imem_addr); else passed++;
  endtask

  task automatic test_reset_call();
    step(16'h0, 3'd0, C_RST);
    step(mk_off(10'h0AA), 3'd0, C_CALL);
    step(mk_off(10'h0BB), 3'd0, C_CALL | C_RST);
    checks++; if (imem_addr !== 10'h000) $display("FAIL rstcall_pc: got %0h expected 0", imem_addr); else passed++;
    checks++; if (stack_err !== 1'b0) $display("FAIL rstcall_err: got %b expected 0", stack_err); else passed++;
    step(16'h0, 3'd0, C_RET);
    checks++; if (imem_addr !== 10'h001) $display("FAIL rstcall_sp0_pc: got %0h expected 1", imem_addr); else passed++;
    checks++; if (stack_err !== 1'b1) $display("FAIL rstcall_sp0_err: got %b expected 1", stack_err); else passed++;
  endtask

  task automatic test_random();
    int ctl;
    step(16'h0, 3'd0, C_RST);
    for (int r = 1; r < 16; r++) step(mk_imm($urandom_range(255), r), 3'd0, C_INC | C_INM | C_WE);
    for (int i = 0; i < 400; i++) begin
      ctl = 0;
      if ($urandom_range(3) != 0) ctl |= C_INC;
      if ($urandom_range(1) != 0) ctl |= C_SKIP;
      if ($urandom_range(1) != 0) ctl |= C_INM;
      if ($urandom_range(1) != 0) ctl |= C_WE;
      if ($urandom_range(1) != 0) ctl |= C_FWE;
      if ($urandom_range(9) == 0) ctl |= C_CALL;
      if ($urandom_range(9) == 0) ctl |= C_RET;
      if ($urandom_range(49) == 0) ctl = (ctl | C_RST) & ~C_WE;
      step(16'($urandom), 3'($urandom_range(7)), ctl);
      checks++; if (imem_addr !== 10'(m_pc)) $display("FAIL rnd_pc: got %0h expected %0h", imem_addr, m_pc); else passed++;
      checks++; if (zero !== m_zero) $display("FAIL rnd_zero: got %b expected %b", zero, m_zero); else passed++;
      checks++; if (carry !== m_carry) $display("FAIL rnd_carry: got %b expected %b", carry, m_carry); else passed++;
      checks++;
      if (stack_full !== (m_stk.size() == SD)) $display("FAIL rnd_full: got %b expected %b", stack_full, m_stk.size() == SD);
      else passed++;
      checks++; if (stack_err !== m_err) $display("FAIL rnd_err: got %b expected %b", stack_err, m_err); else passed++;
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) m_regs[i] = 0;
    m_pc = 0; m_zero = 0; m_carry = 0; m_err = 0;
    test_reset();
    test_inc();
    test_wrap();
    test_alu();
    test_calls();
    test_conflict();
    test_reset_call();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
